// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding,
// and the counter-width helper.
package add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle of the nibble-serial adder; the requester drives
// start/a/b/cin and observes busy/done/sum/cout.
interface nibble_serial_adder_if
  import add_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/nibble_serial_adder_add4.sv
// Existing 4-bit ripple-carry adder slice; purely combinational.
module add4
  import add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
    end
  end

  assign cout_o = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands through one add4 slice, LS nibble first,
// carrying between nibbles in a register; result appears with a done pulse.
module nibble_serial_adder
  import add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       res_q, res_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic [W-1:0]        res_shift;

  add4 u_add4 (
    .a_i    (a_q[NIBBLE_W-1:0]),
    .b_i    (b_q[NIBBLE_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // New nibble enters at the top so the LS nibble ends up at bit 0 after NIBBLES shifts.
  assign res_shift = (res_q >> NIBBLE_W) | (W'(slice_sum) << (W - NIBBLE_W));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        res_d   = res_shift;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = res_shift;
          cout_d  = slice_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 4-nibble instance for the main
// scenarios and a 1-nibble instance for the degenerate build.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();

  nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_pass  = 0;
  int n_total = 0;

  logic [16:0] sb4[$];
  logic [4:0]  sb1[$];

  task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = a;
    bus4.b     = b;
    bus4.cin   = c;
    sb4.push_back({1'b0, a} + {1'b0, b} + 17'(c));
    @(posedge clk);
    #1 bus4.start = 1'b0;
  endtask

  // lat = cycle index (1 = first cycle after the start edge) where done was seen; 0 on timeout
  task automatic wait_done4(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus4.busy) busy_cyc++;
      if (bus4.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    #12;
    n_total++; if (bus4.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus4.busy); else n_pass++;
    n_total++; if (bus4.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus4.done); else n_pass++;
    n_total++; if (bus4.sum !== 16'h0) $display("FAIL reset_sum: got %h expected 0000", bus4.sum); else n_pass++;
    n_total++; if (bus4.cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", bus4.cout); else n_pass++;
    n_total++; if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 7'h0)
      $display("FAIL reset_n1: got %h expected 00", {bus1.busy, bus1.done, bus1.cout, bus1.sum}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [16:0] exp;
    start4(16'h1234, 16'h4321, 1'b0);
    wait_done4(lat, bc);
    exp = sb4.pop_front();
    n_total++; if (lat !== 5) $display("FAIL basic_latency: got %0d expected 5", lat); else n_pass++;
    n_total++; if (bc !== 4) $display("FAIL basic_busy_cycles: got %0d expected 4", bc); else n_pass++;
    n_total++; if ({bus4.cout, bus4.sum} !== exp) $display("FAIL basic_result: got %h expected %h", {bus4.cout, bus4.sum}, exp); else n_pass++;
    @(negedge clk);
    n_total++; if (bus4.done !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", bus4.done); else n_pass++;
    n_total++; if ({bus4.cout, bus4.sum} !== exp) $display("FAIL basic_hold: got %h expected %h", {bus4.cout, bus4.sum}, exp); else n_pass++;
  endtask

  task automatic test_carry();
    int lat, bc;
    logic [16:0] exp;
    logic [15:0] av[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    logic [15:0] bv[3] = '{16'h0001, 16'hFFFF, 16'h0000};
    logic        cv[3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      start4(av[i], bv[i], cv[i]);
      wait_done4(lat, bc);
      exp = sb4.pop_front();
      n_total++; if (lat !== 5) $display("FAIL carry_latency[%0d]: got %0d expected 5", i, lat); else n_pass++;
      n_total++; if ({bus4.cout, bus4.sum} !== exp) $display("FAIL carry_result[%0d]: got %h expected %h", i, {bus4.cout, bus4.sum}, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, done_seen;
    logic [16:0] exp;
    n_total++; if ({bus4.cout, bus4.sum} !== 17'h00001) $display("FAIL midrst_pre_sum: got %h expected 00001", {bus4.cout, bus4.sum}); else n_pass++;
    start4(16'h00FF, 16'h0F01, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_total++; if (bus4.busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", bus4.busy); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus4.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus4.busy); else n_pass++;
    n_total++; if (bus4.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus4.done); else n_pass++;
    n_total++; if (bus4.sum !== 16'h0) $display("FAIL midrst_sum: got %h expected 0000", bus4.sum); else n_pass++;
    n_total++; if (bus4.cout !== 1'b0) $display("FAIL midrst_cout: got %b expected 0", bus4.cout); else n_pass++;
    void'(sb4.pop_front());
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.done) done_seen++;
    end
    n_total++; if (done_seen !== 0) $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen); else n_pass++;
    start4(16'h8000, 16'h8000, 1'b0);
    wait_done4(lat, bc);
    exp = sb4.pop_front();
    n_total++; if (lat !== 5) $display("FAIL midrst_next_latency: got %0d expected 5", lat); else n_pass++;
    n_total++; if ({bus4.cout, bus4.sum} !== exp) $display("FAIL midrst_next_result: got %h expected %h", {bus4.cout, bus4.sum}, exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bc;
    logic [16:0] exp;
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 16'h0F0F; bus4.b = 16'h1111; bus4.cin = 1'b0;
    sb4.push_back({1'b0, 16'h0F0F} + {1'b0, 16'h1111});
    @(posedge clk);
    #1 bus4.a = 16'hAAAA; bus4.b = 16'h5555; bus4.cin = 1'b1;
    lat1 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus4.done) begin
        lat1 = i;
        break;
      end
    end
    exp = sb4.pop_front();
    n_total++; if (lat1 !== 5) $display("FAIL b2b_first_latency: got %0d expected 5", lat1); else n_pass++;
    n_total++; if ({bus4.cout, bus4.sum} !== exp) $display("FAIL b2b_first_result: got %h expected %h", {bus4.cout, bus4.sum}, exp); else n_pass++;
    // start is still high in this DONE cycle, so the held operands are taken at the next edge
    sb4.push_back({1'b0, 16'hAAAA} + {1'b0, 16'h5555} + 17'd1);
    @(posedge clk);
    #1 bus4.start = 1'b0;
    wait_done4(lat2, bc);
    exp = sb4.pop_front();
    n_total++; if (lat2 !== 5) $display("FAIL b2b_second_latency: got %0d expected 5", lat2); else n_pass++;
    n_total++; if ({bus4.cout, bus4.sum} !== exp) $display("FAIL b2b_second_result: got %h expected %h", {bus4.cout, bus4.sum}, exp); else n_pass++;
  endtask

  task automatic test_nibbles1();
    int lat;
    logic [4:0] exp;
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = 4'h9; bus1.b = 4'h8; bus1.cin = 1'b1;
    sb1.push_back({1'b0, 4'h9} + {1'b0, 4'h8} + 5'd1);
    @(posedge clk);
    #1 bus1.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus1.done) begin
        lat = i;
        break;
      end
    end
    exp = sb1.pop_front();
    n_total++; if (lat !== 2) $display("FAIL n1_latency: got %0d expected 2", lat); else n_pass++;
    n_total++; if ({bus1.cout, bus1.sum} !== exp) $display("FAIL n1_result: got %h expected %h", {bus1.cout, bus1.sum}, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_reset_mid_run();
    test_back_to_back();
    test_nibbles1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder that sequences W-bit operands through a single existing 4-bit ripple adder slice (add4), one nibble per clock, least-significant nibble first. It is the control and storage stage wrapped around the 4-bit slice. It latches operands on a start handshake, feeds the slice, carries between nibbles in a register, and presents the registered sum and carry-out with a one-cycle done pulse. It trades latency for area in datapaths wider than 4 bits.

Parameters:
NIBBLES, 4, number of 4-bit slices processed; operand width W = 4*NIBBLES (minimum 1).

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; accepted only when busy=0.
a  input  W  operand A, sampled on accepted start.
b  input  W  operand B, sampled on accepted start.
cin  input  1  carry-in to nibble 0, sampled on accepted start.
busy  output  1  high while a computation is in progress.
done  output  1  one-cycle pulse when sum/cout become valid.
sum  output  W  registered result; holds until next completion.
cout  output  1  registered carry-out of top nibble; holds with sum.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0, nibble counter=0, carry register=0, operand/result shift registers=0. Effective immediately, independent of clk.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On start=1 at edge k: latch a, b into shift registers and cin into the carry register, clear the counter, and go to RUN.
- RUN: busy=1. Each cycle, add4 receives the low nibble of each operand register plus the carry register.
  - At each edge, shift both operand registers right by 4, shift the slice output into the top of the result shift register, load the slice cout into the carry register, and increment the counter.
  - When the counter reaches NIBBLES-1 at the edge, copy the full result into sum and the final carry into cout, then go to DONE.
  - start is ignored in RUN, and a, b and cin are not sampled.
- DONE: busy=0, done=1 for exactly one cycle. The next state is IDLE, or RUN if start=1 in this cycle. A start in DONE is accepted with the same latching as in IDLE.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+NIBBLES. sum and cout are valid from that cycle onward. Back-to-back throughput is one result per NIBBLES+1 cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1). There is no overflow flag.
- sum and cout change only at a completion edge or on reset. Intermediate nibbles are never visible on sum.
- Reset mid-RUN: abort immediately. No done pulse occurs and sum reads 0.
- rst released while start=1: start is sampled normally at the first edge after release.
- NIBBLES=1: RUN lasts one cycle, and done appears 2 cycles after the start edge.

Decomposition:
- Shared package add_pkg contains:
  - NIBBLE_W=4 constant.
  - State typedef {IDLE, RUN, DONE}, encoded as 2 bits.
  - Counter-width function clog2(NIBBLES), minimum 1 bit.
- Exactly one sub-module: the existing add4 slice, instantiated once as the combinational datapath.
- FSM, counter, carry register and shift registers are local to nibble_serial_adder.

Test Plan:
- Reset then a=0x1234, b=0x4321, cin=0, start pulse -> busy high 4 cycles; done pulse at start edge+4; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Carry propagates through all 4 nibbles via the carry register.
- a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Then a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- start held high in RUN with different a/b (0xAAAA/0x5555) -> ignored; first result unchanged. start asserted in the DONE cycle -> accepted; second result correct 5 cycles later.
- Assert rst asynchronously mid-RUN (between edges, after 2 nibbles) -> busy, done, sum and cout go to 0 without a clock edge. No done pulse follows; the next start computes correctly.
- NIBBLES=1 build: a=0x9, b=0x8, cin=1 -> sum=0x2, cout=1; done 2 cycles after the start edge.
